// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Purpose  : RISC-V instruction-fetch stage. Owns the PC, generates PC+4,
//             applies redirect/stall/flush, drives the program-memory address
//             and registers the fetched word into the IF/ID pipeline register.
//             Also keeps saturating fetch and bubble counters.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0040_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall_i,
  input  logic                 flush_i,
  input  logic                 redirect_i,
  input  logic [31:0]          redirect_target_i,
  output logic [31:0]          imem_addr_o,
  input  logic [31:0]          imem_data_i,
  output logic [31:0]          if_id_instr_o,
  output logic [31:0]          if_id_pc_o,
  output logic [31:0]          if_id_pc_plus_4_o,
  output logic                 if_id_valid_o,
  output logic [CNT_WIDTH-1:0] fetch_count_o,
  output logic [CNT_WIDTH-1:0] bubble_count_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic [31:0] pc_q;
  logic [31:0] pc_plus_4;
  logic [31:0] pc_next;
  logic        load_bubble;
  logic        load_valid;

  // Program memory is addressed straight from the PC register, so the address
  // never depends on any same-cycle input.
  assign imem_addr_o = pc_q;
  assign pc_plus_4   = pc_q + 32'd4;

  // Resolve the edge action: redirect beats stall, stall beats flush for the
  // PC, but a flush always turns the IF/ID load into a bubble.
  always_comb begin
    pc_next     = pc_plus_4;
    load_bubble = 1'b0;
    load_valid  = 1'b0;
    if (redirect_i) begin
      pc_next     = {redirect_target_i[31:2], 2'b00};
      load_bubble = 1'b1;
    end else if (stall_i) begin
      pc_next     = pc_q;
      load_bubble = flush_i;
    end else if (flush_i) begin
      load_bubble = 1'b1;
    end else begin
      load_valid  = 1'b1;
    end
  end

  // PC register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_next;
    end
  end

  // IF/ID pipeline register: load a real instruction, a bubble, or hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_id_instr_o     <= NOP_INSTR;
      if_id_pc_o        <= 32'd0;
      if_id_pc_plus_4_o <= 32'd0;
      if_id_valid_o     <= 1'b0;
    end else if (load_bubble) begin
      if_id_instr_o     <= NOP_INSTR;
      if_id_pc_o        <= 32'd0;
      if_id_pc_plus_4_o <= 32'd0;
      if_id_valid_o     <= 1'b0;
    end else if (load_valid) begin
      if_id_instr_o     <= imem_data_i;
      if_id_pc_o        <= pc_q;
      if_id_pc_plus_4_o <= pc_plus_4;
      if_id_valid_o     <= 1'b1;
    end
  end

  // Saturating performance counters; they stick at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_count_o  <= '0;
      bubble_count_o <= '0;
    end else begin
      if (load_valid && (fetch_count_o != CNT_MAX)) begin
        fetch_count_o <= fetch_count_o + CNT_ONE;
      end
      if (load_bubble && (bubble_count_o != CNT_MAX)) begin
        bubble_count_o <= bubble_count_o + CNT_ONE;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_stage
//  Purpose  : Self-checking bench for fetch_stage. A behavioural model tracks
//             PC, IF/ID contents and event counts; a second instance with
//             3-bit counters exercises saturation.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC  = 32'h0040_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush, redirect;
  logic [31:0] target;
  logic [31:0] imem_addr, imem_data, instr, ipc, ipc4;
  logic        valid;
  logic [31:0] fcnt, bcnt;

  logic [31:0] imem_addr_s, imem_data_s, instr_s, ipc_s, ipc4_s;
  logic        valid_s;
  logic [2:0]  fcnt_s, bcnt_s;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] m_pc, m_instr, m_ipc, m_ipc4, m_fetch, m_bubble;
  logic        m_valid;

  always #5 clk = ~clk;

  // Program memory contents: a fixed word at RESET_PC, a hash elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0040_0000) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  assign imem_data   = mem_word(imem_addr);
  assign imem_data_s = mem_word(imem_addr_s);

  fetch_stage dut (
    .clk(clk), .reset(reset), .stall_i(stall), .flush_i(flush),
    .redirect_i(redirect), .redirect_target_i(target),
    .imem_addr_o(imem_addr), .imem_data_i(imem_data),
    .if_id_instr_o(instr), .if_id_pc_o(ipc), .if_id_pc_plus_4_o(ipc4),
    .if_id_valid_o(valid), .fetch_count_o(fcnt), .bubble_count_o(bcnt)
  );

  fetch_stage #(.CNT_WIDTH(3)) dut_sat (
    .clk(clk), .reset(reset), .stall_i(stall), .flush_i(flush),
    .redirect_i(redirect), .redirect_target_i(target),
    .imem_addr_o(imem_addr_s), .imem_data_i(imem_data_s),
    .if_id_instr_o(instr_s), .if_id_pc_o(ipc_s), .if_id_pc_plus_4_o(ipc4_s),
    .if_id_valid_o(valid_s), .fetch_count_o(fcnt_s), .bubble_count_o(bcnt_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sat7(input logic [31:0] v);
    return (v > 32'd7) ? 32'd7 : v;
  endfunction

  task automatic model_reset();
    m_pc = RESET_PC; m_instr = NOP_INSTR; m_ipc = 0; m_ipc4 = 0;
    m_valid = 1'b0; m_fetch = 0; m_bubble = 0;
  endtask

  task automatic model_bubble();
    m_instr = NOP_INSTR; m_ipc = 0; m_ipc4 = 0; m_valid = 1'b0;
    m_bubble = m_bubble + 1;
  endtask

  // One rising edge of the fetch stage expressed as its priority rules.
  task automatic model_edge(input logic r, input logic s, input logic f, input logic [31:0] t);
    if (r) begin
      m_pc = t & 32'hFFFF_FFFC;
      model_bubble();
    end else if (s) begin
      if (f) model_bubble();
    end else if (f) begin
      m_pc = m_pc + 32'd4;
      model_bubble();
    end else begin
      m_instr = mem_word(m_pc);
      m_ipc   = m_pc;
      m_ipc4  = m_pc + 32'd4;
      m_valid = 1'b1;
      m_pc    = m_pc + 32'd4;
      m_fetch = m_fetch + 1;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},        imem_addr,       m_pc);
    chk({tag, ".instr"},     instr,           m_instr);
    chk({tag, ".ipc"},       ipc,             m_ipc);
    chk({tag, ".ipc4"},      ipc4,            m_ipc4);
    chk({tag, ".valid"},     {31'd0, valid},  {31'd0, m_valid});
    chk({tag, ".fetch"},     fcnt,            m_fetch);
    chk({tag, ".bubble"},    bcnt,            m_bubble);
    chk({tag, ".fetch_sat"}, {29'd0, fcnt_s}, sat7(m_fetch));
    chk({tag, ".bub_sat"},   {29'd0, bcnt_s}, sat7(m_bubble));
  endtask

  // Drive inputs between edges, take one edge, then sample 1 time unit later.
  task automatic step(input string tag, input logic r, input logic s, input logic f,
                      input logic [31:0] t);
    redirect = r; stall = s; flush = f; target = t;
    @(posedge clk);
    model_edge(r, s, f, t);
    #1;
    check_all(tag);
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; flush = 1'b0; redirect = 1'b0; target = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");

    // First fetch after reset release
    reset = 1'b1;
    step("first", 0, 0, 0, 0);
    chk("first_instr_const", instr, 32'h0050_0093);
    chk("first_ipc4_const",  ipc4,  32'h0040_0004);

    // Free run then stall for two cycles
    step("run2", 0, 0, 0, 0);
    step("run3", 0, 0, 0, 0);
    chk("pc_before_stall", imem_addr, 32'h0040_000C);
    step("stall1", 0, 1, 0, 0);
    step("stall2", 0, 1, 0, 0);
    chk("fetch_held_const", fcnt, 32'd3);
    step("post_stall", 0, 0, 0, 0);
    chk("post_stall_ipc", ipc, 32'h0040_000C);

    // Flush alone at 0x00400010
    step("flush", 0, 0, 1, 0);
    chk("flush_pc_const", imem_addr, 32'h0040_0014);

    // Redirect wins over stall+flush; target low bits dropped
    step("redir", 1, 1, 1, 32'h0040_0023);
    chk("redir_pc_const", imem_addr, 32'h0040_0020);
    step("after_redir", 0, 0, 0, 0);
    chk("after_redir_ipc", ipc, 32'h0040_0020);

    // Stall with flush: PC held, bubble loaded
    step("stall_flush", 0, 1, 1, 0);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      step("rand", ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 4) == 0), $urandom);
    end

    // PC wrap at the top of the address space
    step("to_top", 1, 0, 0, 32'hFFFF_FFFF);
    step("wrap", 0, 0, 0, 0);
    chk("wrap_pc_const",   imem_addr, 32'h0000_0000);
    chk("wrap_ipc4_const", ipc4,      32'h0000_0000);

    // Asynchronous reset between edges at pc 0x00400040
    step("to_40", 1, 0, 0, 32'h0040_0040);
    step("at_40", 0, 0, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    chk("async_reset_addr", imem_addr, RESET_PC);
    #1;
    reset = 1'b1;
    step("restart1", 0, 0, 0, 0);
    step("restart2", 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
